// File: rtl/pam4_pkg.sv
// Shared PAM4 definitions: default word format, default slicer levels,
// calibrator state encoding and saturation helpers.
package pam4_pkg;

  localparam int PAM4_NB  = 8;
  localparam int PAM4_NBF = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_UPDATE = 2'd2
  } cal_state_t;

  // quarters of full scale: q_frac(1,nbf)=0.25, (2)=0.5, (3)=0.75
  function automatic int q_frac(input int quarters, input int nbf);
    return (quarters << nbf) >> 2;
  endfunction

  function automatic int max_pos(input int nb);
    return (1 << (nb - 1)) - 1;
  endfunction

  localparam int PAM4_LVL_Q25 = q_frac(1, PAM4_NBF);
  localparam int PAM4_LVL_Q50 = q_frac(2, PAM4_NBF);
  localparam int PAM4_LVL_Q75 = q_frac(3, PAM4_NBF);
  localparam int PAM4_MAX_POS = max_pos(PAM4_NB);

endpackage

// File: rtl/pam4_abs_sat.sv
// Saturating absolute value of an NB-bit signed word.
// Ports: x (signed in), y (non-negative out, most negative maps to max).
module pam4_abs_sat #(
  parameter int NB = 8
) (
  input  logic signed [NB-1:0] x,
  output logic        [NB-1:0] y
);

  localparam logic [NB-1:0] MINV = {1'b1, {(NB-1){1'b0}}};
  localparam logic [NB-1:0] MAXV = {1'b0, {(NB-1){1'b1}}};
  localparam logic [NB-1:0] ONE  = {{(NB-1){1'b0}}, 1'b1};

  logic [NB-1:0] xu;

  assign xu = x;

  always_comb begin
    if (xu == MINV)
      y = MAXV;
    else if (xu[NB-1])
      y = ~xu + ONE;
    else
      y = xu;
  end

endmodule

// File: rtl/pam4_level_calibrator.sv
// PAM4 threshold/level calibrator: averages |x| over 2^LOG2N samples.
// Ports: sample stream in, start/continuous ctl, th/levels/flags out.
module pam4_level_calibrator
  import pam4_pkg::*;
#(
  parameter int NB    = PAM4_NB,
  parameter int NBF   = PAM4_NBF,
  parameter int LOG2N = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic signed [NB-1:0] i_sample,
  input  logic                 i_start,
  input  logic                 i_continuous,
  output logic signed [NB-1:0] o_th_pos,
  output logic signed [NB-1:0] o_lvl_inner,
  output logic signed [NB-1:0] o_lvl_outer,
  output logic                 o_cfg_valid,
  output logic                 o_busy,
  output logic                 o_locked
);

  localparam int AW = NB - 1 + LOG2N;

  localparam logic [NB-1:0] TH_RST = NB'(q_frac(2, NBF));
  localparam logic [NB-1:0] LI_RST = NB'(q_frac(1, NBF));
  localparam logic [NB-1:0] LO_RST = NB'(q_frac(3, NBF));
  localparam logic [NB-1:0] MAXP   = NB'(max_pos(NB));

  cal_state_t       state;
  cal_state_t       state_nx;
  logic             accept;
  logic             last;
  logic             acc_clr;
  logic             acc_en;
  logic             upd;
  logic             busy_nx;
  logic [LOG2N-1:0] cnt;
  logic [AW-1:0]    acc;
  logic [NB-1:0]    mag;
  logic [NB-2:0]    mean;
  logic [NB-1:0]    sum;
  logic [NB-1:0]    outer;

  pam4_abs_sat #(.NB(NB)) u_abs (
    .x(i_sample),
    .y(mag)
  );

  assign accept = i_enable & i_valid;
  assign last   = accept && (cnt == '1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (i_start) state_nx = ST_ACQ;
      ST_ACQ:    if (last) state_nx = ST_UPDATE;
      ST_UPDATE: state_nx = i_continuous ? ST_ACQ : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    upd     = 1'b0;
    unique case (1'b1)
      (state == ST_ACQ):    acc_en  = accept;
      (state == ST_UPDATE): begin
        upd     = 1'b1;
        acc_clr = 1'b1;
      end
      default:              acc_clr = 1'b1;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  // sum of mean and mean/2 fits NB bits unsigned; clamp to max positive
  assign mean  = acc[AW-1:LOG2N];
  assign sum   = {1'b0, mean} + {2'b00, mean[NB-2:1]};
  assign outer = (sum > MAXP) ? MAXP : sum;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc         <= '0;
      cnt         <= '0;
      o_th_pos    <= TH_RST;
      o_lvl_inner <= LI_RST;
      o_lvl_outer <= LO_RST;
      o_cfg_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_locked    <= 1'b0;
    end else begin
      o_busy      <= busy_nx;
      o_cfg_valid <= 1'b0;
      if (acc_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (acc_en) begin
        acc <= acc + {{(LOG2N-1){1'b0}}, mag};
        cnt <= cnt + 1'b1;
      end
      if (upd) begin
        if (mean != '0) begin
          o_th_pos    <= {1'b0, mean};
          o_lvl_inner <= {2'b00, mean[NB-2:1]};
          o_lvl_outer <= outer;
          o_cfg_valid <= 1'b1;
          o_locked    <= 1'b1;
        end else begin
          o_locked    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pam4_level_calibrator.sv
// Directed bench for pam4_level_calibrator (NB=8, NBF=7, LOG2N=4).
// Hand-computed expectations; all checks via one task.
module tb_pam4_level_calibrator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              vld = 1'b0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic signed [7:0] smp = '0;
  logic signed [7:0] th;
  logic signed [7:0] inner;
  logic signed [7:0] outer;
  logic              cfgv;
  logic              busy;
  logic              locked;

  int total = 0;
  int bad = 0;
  int npulse = 0;
  int n0;
  logic [7:0] rec [8];

  pam4_level_calibrator #(.NB(8), .NBF(7), .LOG2N(4)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_enable    (en),
    .i_valid     (vld),
    .i_sample    (smp),
    .i_start     (start),
    .i_continuous(cont),
    .o_th_pos    (th),
    .o_lvl_inner (inner),
    .o_lvl_outer (outer),
    .o_cfg_valid (cfgv),
    .o_busy      (busy),
    .o_locked    (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfgv) begin
      if (npulse < 8) rec[npulse] = th;
      npulse = npulse + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic e, input logic v,
                     input logic signed [7:0] s);
    en = e;
    vld = v;
    smp = s;
    tick();
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // called right after the edge that accepted the 16th sample
  task automatic end_win(input string tg, input logic pe,
                         input logic [7:0] the, input logic [7:0] ine,
                         input logic [7:0] oute, input logic lke);
    int p0;
    p0 = npulse;
    check({tg, "_pre_cfgv"}, cfgv, 0);
    check({tg, "_pre_busy"}, busy, 1);
    put(1'b1, 1'b0, 8'sd0);
    check({tg, "_cfgv"}, cfgv, pe);
    check({tg, "_th"}, th, the);
    check({tg, "_inner"}, inner, ine);
    check({tg, "_outer"}, outer, oute);
    check({tg, "_locked"}, locked, lke);
    check({tg, "_busy"}, busy, 0);
    tick();
    check({tg, "_post_cfgv"}, cfgv, 0);
    check({tg, "_npulse"}, npulse - p0, pe);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_th", th, 64);
    check("rst_inner", inner, 32);
    check("rst_outer", outer, 96);
    check("rst_flags", {cfgv, busy, locked}, 0);
    rst_n = 1'b1;

    // valid traffic without start: nothing moves
    for (int i = 0; i < 10; i++) put(1'b1, 1'b1, 8'sd100);
    check("idle_th", th, 64);
    check("idle_inner", inner, 32);
    check("idle_outer", outer, 96);
    check("idle_flags", {cfgv, busy, locked}, 0);
    check("idle_npulse", npulse, 0);

    // +-64
    kick();
    for (int i = 0; i < 16; i++)
      put(1'b1, 1'b1, (i % 2) ? -8'sd64 : 8'sd64);
    end_win("w64", 1'b1, 8'd64, 8'd32, 8'd96, 1'b1);

    // +-40, gaps, enable drop with junk, ignored start
    kick();
    for (int i = 0; i < 16; i++) begin
      if (i == 6)
        for (int k = 0; k < 5; k++) put(1'b0, 1'b1, 8'sd127);
      if (i == 9) begin
        start = 1'b1;
        put(1'b1, 1'b0, 8'sd0);
        start = 1'b0;
      end
      put(1'b1, 1'b1, (i % 2) ? -8'sd40 : 8'sd40);
      if (i != 15) put(1'b1, 1'b0, 8'sd99);
    end
    end_win("w40", 1'b1, 8'd40, 8'd20, 8'd60, 1'b1);

    // -128 saturates to 127, outer clamps
    kick();
    for (int i = 0; i < 16; i++) put(1'b1, 1'b1, -8'sd128);
    end_win("wmin", 1'b1, 8'd127, 8'd63, 8'd127, 1'b1);

    // zeros: no update, unlock
    kick();
    for (int i = 0; i < 16; i++) put(1'b1, 1'b1, 8'sd0);
    end_win("wzero", 1'b0, 8'd127, 8'd63, 8'd127, 1'b0);

    // continuous: windows 64,64,(6x64+10x32)/16=44,32
    cont = 1'b1;
    kick();
    n0 = npulse;
    for (int k = 1; k <= 74; k++)
      put(1'b1, 1'b1, (k <= 40) ? 8'sd64 : 8'sd32);
    check("cont_npulse", npulse - n0, 4);
    check("cont_th0", rec[n0], 64);
    check("cont_th1", rec[n0 + 1], 64);
    check("cont_th2", rec[n0 + 2], 44);
    check("cont_th3", rec[n0 + 3], 32);
    check("cont_inner", inner, 16);
    check("cont_outer", outer, 48);
    check("cont_locked", locked, 1);
    check("cont_busy", busy, 1);

    // async reset mid-window
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_th", th, 64);
    check("arst_inner", inner, 32);
    check("arst_outer", outer, 96);
    check("arst_flags", {cfgv, busy, locked}, 0);
    tick();
    rst_n = 1'b1;
    n0 = npulse;
    for (int i = 0; i < 20; i++) put(1'b1, 1'b1, 8'sd64);
    check("arst_idle_busy", busy, 0);
    check("arst_idle_npulse", npulse - n0, 0);
    check("arst_idle_th", th, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
